// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared M-extension decode constants and FSM state type
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M multiply/divide with done pulse and stall
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit FAST_PATH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  Flush,
  input  logic [1:0]            ALUOp,
  input  logic [6:0]            Funct7,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  IsMulDiv,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Stall,
  output logic [DATA_WIDTH-1:0] Result
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] op;
  logic sa, neg;
  logic [W-1:0] opnd;
  logic [2*W-1:0] prod;
  logic accept, is_div, sa_in, sb_in, b_zero, ovf, fast;
  logic [W-1:0] a_mag, b_mag, fast_res, quo, rem, res_nx;
  logic [W:0] mul_sum, div_sh, div_df;
  logic [2*W-1:0] mul_nx, div_nx, step, mul_p;
  assign IsMulDiv = (ALUOp == ALUOP_RTYPE) && (Funct7 == FUNCT7_MULDIV);
  assign Busy     = state != IDLE;
  assign Done     = state == DONE;
  assign Stall    = IsMulDiv && Start && !Done;
  // prod holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    accept   = (state == IDLE) && Start && IsMulDiv && !Flush;
    is_div   = Funct3[2];
    sa_in    = SrcA[W-1] && (is_div ? !Funct3[0] : Funct3[1:0] != 2'b11);
    sb_in    = SrcB[W-1] && (is_div ? !Funct3[0] : !Funct3[1]);
    a_mag    = sa_in ? -SrcA : SrcA;
    b_mag    = sb_in ? -SrcB : SrcB;
    b_zero   = SrcB == '0;
    ovf      = !Funct3[0] && SrcA == {1'b1, {(W-1){1'b0}}} && SrcB == '1;
    fast     = FAST_PATH && is_div && (b_zero || ovf);
    fast_res = Funct3[1] ? (b_zero ? SrcA : '0) : (b_zero ? '1 : SrcA);
    mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opnd} : '0);
    mul_nx   = {mul_sum, prod[W-1:1]};
    div_sh   = {prod[2*W-1:W], prod[W-1]};
    div_df   = div_sh - {1'b0, opnd};
    div_nx   = div_df[W] ? {div_sh[W-1:0], prod[W-2:0], 1'b0} : {div_df[W-1:0], prod[W-2:0], 1'b1};
    step     = state == MUL ? mul_nx : div_nx;
    mul_p    = neg ? -step : step;
    quo      = neg ? -step[W-1:0] : step[W-1:0];
    rem      = sa ? -step[2*W-1:W] : step[2*W-1:W];
    res_nx   = state == MUL ? (op[1:0] == 2'b00 ? mul_p[W-1:0] : mul_p[2*W-1:W]) : (op[1] ? rem : quo);
  end
  // a zero divisor keeps the quotient all ones, so its sign is never applied
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      Result <= '0;
      op     <= '0;
      sa     <= 1'b0;
      neg    <= 1'b0;
      opnd   <= '0;
      prod   <= '0;
    end else if (Flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op    <= Funct3;
          sa    <= sa_in;
          neg   <= (sa_in ^ sb_in) && !b_zero;
          cnt   <= '0;
          prod  <= {{W{1'b0}}, is_div ? a_mag : b_mag};
          opnd  <= is_div ? b_mag : a_mag;
          state <= fast ? DONE : (is_div ? DIV : MUL);
          if (fast) Result <= fast_res;
        end
        MUL, DIV: begin
          prod <= step;
          cnt  <= cnt == LAST ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            Result <= res_nx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus flush/reset/ignore sequences
module tb_muldiv_unit;
  import muldiv_pkg::*;
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  localparam int NV = 15;
  logic clk = 1'b0, reset = 1'b1, Start = 1'b0, Flush = 1'b0;
  logic [1:0] ALUOp = ALUOP_RTYPE;
  logic [6:0] Funct7 = FUNCT7_MULDIV;
  logic [2:0] Funct3 = 3'b000;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic IsMulDiv, Busy, Done, Stall;
  logic [31:0] Result;
  int n_cmp = 0, n_bad = 0;
  vec_t vec[NV];
  muldiv_unit dut (
    .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .ALUOp(ALUOp), .Funct7(Funct7),
    .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .IsMulDiv(IsMulDiv), .Busy(Busy), .Done(Done),
    .Stall(Stall), .Result(Result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Funct3 = f3;
    SrcA = a;
    SrcB = b;
    Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
  endtask
  task automatic wait_done(output logic [31:0] r, output int lat, output int bz);
    r = '0;
    lat = 0;
    bz = 0;
    for (int n = 1; n <= 100; n++) begin
      if (n > 1) @(negedge clk);
      if (Busy) bz++;
      if (Done) begin
        lat = n;
        r = Result;
        break;
      end
    end
  endtask
  initial begin
    logic [31:0] r;
    int lat, bz, seen;
    vec[0]  = '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vec[1]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vec[2]  = '{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vec[3]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vec[4]  = '{F3_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
    vec[5]  = '{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vec[6]  = '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vec[7]  = '{F3_DIVU,   32'd100,      32'd7,        32'd14,       33};
    vec[8]  = '{F3_REMU,   32'd100,      32'd7,        32'd2,        33};
    vec[9]  = '{F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vec[10] = '{F3_REMU,   32'd5,        32'd0,        32'd5,        1};
    vec[11] = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vec[12] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vec[13] = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
    vec[14] = '{F3_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_result", Result, 0);
    @(negedge clk);
    Start = 1'b1;
    #1 chk("stall_on_start", Stall, 1);
    Start = 1'b0;
    for (int i = 0; i < NV; i++) begin
      issue(vec[i].f3, vec[i].a, vec[i].b);
      wait_done(r, lat, bz);
      chk($sformatf("vec%0d_result", i), r, vec[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vec[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bz, vec[i].lat);
    end
    issue(F3_MUL, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    chk("flush_busy", Busy, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) seen = 1;
    end
    chk("flush_no_done", seen, 0);
    chk("flush_result_held", Result, vec[NV-1].exp);
    Start = 1'b1;
    Flush = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    Flush = 1'b0;
    chk("flush_beats_start", Busy, 0);
    @(negedge clk);
    Funct7 = 7'b0000000;
    Start = 1'b1;
    #1 chk("f7_ismuldiv", IsMulDiv, 0);
    chk("f7_stall", Stall, 0);
    @(negedge clk);
    Start = 1'b0;
    Funct7 = FUNCT7_MULDIV;
    chk("f7_ignored", Busy, 0);
    issue(F3_MUL, 32'd6, 32'd7);
    repeat (2) @(negedge clk);
    Funct3 = F3_DIVU;
    SrcA = 32'd100;
    SrcB = 32'd7;
    Start = 1'b1;
    #1 chk("busy_start_stall", Stall, 1);
    @(negedge clk);
    Start = 1'b0;
    wait_done(r, lat, bz);
    chk("busy_start_result", r, 32'd42);
    chk("busy_start_latency", lat, 30);
    @(negedge clk);
    chk("busy_start_idle", Busy, 0);
    issue(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_mid_busy", Busy, 0);
    chk("rst_mid_done", Done, 0);
    chk("rst_mid_result", Result, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) seen = 1;
    end
    chk("rst_mid_no_done", seen, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
